// File: rtl/tlb_op_ctrl_if.sv
// Bundle between tlb_op_ctrl and its neighbours: pipeline op handshake,
// CP0 operands/write-back, TLB request/response. master = controller side.
interface tlb_op_ctrl_if #(
  parameter int INDEX_W = 4
);
  logic               op_valid;
  logic [1:0]         op_type;
  logic               op_ready;
  logic               op_flush;
  logic               op_done;
  logic               op_err;
  logic [31:0]        cp0_index;
  logic [31:0]        cp0_entryhi;
  logic [31:0]        cp0_entrylo0;
  logic [31:0]        cp0_entrylo1;
  logic               tlb_req;
  logic               tlb_req_ready;
  logic [1:0]         tlb_req_op;
  logic [INDEX_W-1:0] tlb_req_idx;
  logic [31:0]        tlb_req_entryhi;
  logic [31:0]        tlb_req_entrylo0;
  logic [31:0]        tlb_req_entrylo1;
  logic               tlb_resp_valid;
  logic               tlb_resp_hit;
  logic [INDEX_W-1:0] tlb_resp_idx;
  logic [31:0]        tlb_resp_entryhi;
  logic [31:0]        tlb_resp_entrylo0;
  logic [31:0]        tlb_resp_entrylo1;
  logic               w_cp0_tlbp_ena;
  logic               w_cp0_tlbr_ena;
  logic [31:0]        w_cp0_Index;
  logic [31:0]        w_cp0_EntryHi;
  logic [31:0]        w_cp0_EntryLo0;
  logic [31:0]        w_cp0_EntryLo1;
  logic [INDEX_W-1:0] random;

  modport master (
    input  op_valid, op_type, op_flush,
    input  cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
    input  tlb_req_ready, tlb_resp_valid, tlb_resp_hit,
    input  tlb_resp_idx, tlb_resp_entryhi,
    input  tlb_resp_entrylo0, tlb_resp_entrylo1,
    output op_ready, op_done, op_err,
    output tlb_req, tlb_req_op, tlb_req_idx,
    output tlb_req_entryhi, tlb_req_entrylo0, tlb_req_entrylo1,
    output w_cp0_tlbp_ena, w_cp0_tlbr_ena,
    output w_cp0_Index, w_cp0_EntryHi,
    output w_cp0_EntryLo0, w_cp0_EntryLo1,
    output random
  );

  modport slave (
    output op_valid, op_type, op_flush,
    output cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
    output tlb_req_ready, tlb_resp_valid, tlb_resp_hit,
    output tlb_resp_idx, tlb_resp_entryhi,
    output tlb_resp_entrylo0, tlb_resp_entrylo1,
    input  op_ready, op_done, op_err,
    input  tlb_req, tlb_req_op, tlb_req_idx,
    input  tlb_req_entryhi, tlb_req_entrylo0, tlb_req_entrylo1,
    input  w_cp0_tlbp_ena, w_cp0_tlbr_ena,
    input  w_cp0_Index, w_cp0_EntryHi,
    input  w_cp0_EntryLo0, w_cp0_EntryLo1,
    input  random
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLBP/TLBR/TLBWI/TLBWR sequencer: pipeline op -> TLB req/resp -> CP0 write.
// Ports: clk, rst (async high), bus (tlb_op_ctrl_if.master). Owns Random.
module tlb_op_ctrl #(
  parameter int TLB_ENTRIES = 16,
  parameter int INDEX_W     = 4,
  parameter int TIMEOUT     = 64
) (
  input logic           clk,
  input logic           rst,
  tlb_op_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_COMMIT
  } state_e;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic [1:0]         op_q;
  logic [INDEX_W-1:0] idx_q;
  logic [31:0]        hi_q, lo0_q, lo1_q;
  logic               ready_q, req_q, done_q, err_q;
  logic               tlbp_q, tlbr_q;
  logic [31:0]        windex_q, whi_q, wlo0_q, wlo1_q;
  logic [INDEX_W-1:0] rnd_q, rnd_d;
  logic               tmo;

  // >= so a flush landing on the last WAIT cycle still ends DRAIN
  assign tmo = cnt_q >= 8'(TIMEOUT - 1);

  assign rnd_d = (rnd_q == '0) ? INDEX_W'(TLB_ENTRIES - 1)
                               : rnd_q - INDEX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rnd_q <= INDEX_W'(TLB_ENTRIES - 1);
    else     rnd_q <= rnd_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      hi_q     <= '0;
      lo0_q    <= '0;
      lo1_q    <= '0;
      ready_q  <= 1'b1;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tlbp_q   <= 1'b0;
      tlbr_q   <= 1'b0;
      windex_q <= '0;
      whi_q    <= '0;
      wlo0_q   <= '0;
      wlo1_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      tlbp_q <= 1'b0;
      tlbr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.op_valid && !bus.op_flush) begin
            op_q    <= bus.op_type;
            hi_q    <= bus.cp0_entryhi;
            lo0_q   <= bus.cp0_entrylo0;
            lo1_q   <= bus.cp0_entrylo1;
            unique case (bus.op_type)
              OP_TLBP:  idx_q <= '0;
              OP_TLBWR: idx_q <= rnd_q;
              default:  idx_q <= bus.cp0_index[INDEX_W-1:0];
            endcase
            ready_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.op_flush) begin
            req_q   <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (bus.tlb_req_ready) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.op_flush) begin
            state_q <= S_DRAIN;
          end else if (bus.tlb_resp_valid) begin
            done_q  <= 1'b1;
            state_q <= S_COMMIT;
            if (op_q == OP_TLBP) begin
              tlbp_q   <= 1'b1;
              windex_q <= bus.tlb_resp_hit
                ? {{(32-INDEX_W){1'b0}}, bus.tlb_resp_idx}
                : 32'h8000_0000;
            end else if (op_q == OP_TLBR) begin
              tlbr_q <= 1'b1;
              whi_q  <= {bus.tlb_resp_entryhi[31:13], 5'b0,
                         bus.tlb_resp_entryhi[7:0]};
              wlo0_q <= {6'b0, bus.tlb_resp_entrylo0[25:0]};
              wlo1_q <= {6'b0, bus.tlb_resp_entrylo1[25:0]};
            end
          end else if (tmo) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_COMMIT;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.tlb_resp_valid || tmo) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_COMMIT: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          req_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.op_ready         = ready_q;
  assign bus.op_done          = done_q;
  assign bus.op_err           = err_q;
  assign bus.tlb_req          = req_q;
  assign bus.tlb_req_op       = op_q;
  assign bus.tlb_req_idx      = idx_q;
  assign bus.tlb_req_entryhi  = hi_q;
  assign bus.tlb_req_entrylo0 = lo0_q;
  assign bus.tlb_req_entrylo1 = lo1_q;
  assign bus.w_cp0_tlbp_ena   = tlbp_q;
  assign bus.w_cp0_tlbr_ena   = tlbr_q;
  assign bus.w_cp0_Index      = windex_q;
  assign bus.w_cp0_EntryHi    = whi_q;
  assign bus.w_cp0_EntryLo0   = wlo0_q;
  assign bus.w_cp0_EntryLo1   = wlo1_q;
  assign bus.random           = rnd_q;

  logic unused_bits;
  assign unused_bits = ^{bus.cp0_index[31:INDEX_W],
                         bus.tlb_resp_entryhi[12:8],
                         bus.tlb_resp_entrylo0[31:26],
                         bus.tlb_resp_entrylo1[31:26]};

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Multi-cycle sequencer for the TLBP/TLBR/TLBWI/TLBWR instructions, sitting between the memory-stage pipeline, the TLB array and the CP0 register file. It takes one TLB instruction at a time from the pipeline and captures CP0 Index/EntryHi/EntryLo0/EntryLo1 operands. It issues a request to the TLB over a valid/ready handshake and waits for the TLB response, with a timeout. It then pulses the CP0 tlbp/tlbr update strobes with formatted results. It also owns the free-running Random counter used by TLBWR.

## Interface
- TLB_ENTRIES, 16: number of TLB entries; power of two, 2..64
- INDEX_W, 4: log2(TLB_ENTRIES)
- TIMEOUT, 64: max cycles waited for a TLB response; 2..255
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  pipeline presents a TLB instruction
- op_type  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_ready  out  1  controller idle, can accept
- op_flush  in  1  pipeline exception; abandon the in-flight op
- op_done  out  1  one-cycle pulse, op finished (pipeline releases stall)
- op_err  out  1  qualifies op_done: TLB timed out
- cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1  in  32 each  current CP0 values
- tlb_req  out  1  request valid
- tlb_req_ready  in  1  TLB accepts request
- tlb_req_op  out  2  copy of captured op_type
- tlb_req_idx  out  INDEX_W  read/write index
- tlb_req_entryhi, tlb_req_entrylo0, tlb_req_entrylo1  out  32 each  probe key / write data
- tlb_resp_valid  in  1  one-cycle response pulse
- tlb_resp_hit  in  1  probe hit
- tlb_resp_idx  in  INDEX_W  probe hit index
- tlb_resp_entryhi, tlb_resp_entrylo0, tlb_resp_entrylo1  in  32 each  read data
- w_cp0_tlbp_ena  out  1  write Index
- w_cp0_tlbr_ena  out  1  write EntryHi/EntryLo0/EntryLo1
- w_cp0_Index, w_cp0_EntryHi, w_cp0_EntryLo0, w_cp0_EntryLo1  out  32 each  CP0 write data
- random  out  INDEX_W  Random register value

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, COMMIT.
- IDLE: op_ready=1. On op_valid & !op_flush, capture op_type and all four cp0_* inputs. For TLBWR, also snapshot random. Go to ISSUE.
- ISSUE: tlb_req=1 with stable fields until tlb_req_ready. Go to WAIT and clear the timeout counter. On op_flush before acceptance, drop tlb_req and go to IDLE with no op_done.
- Request fields:
  - tlb_req_idx: cp0_index[INDEX_W-1:0] for TLBR/TLBWI, the snapshot for TLBWR, 0 for TLBP.
  - entry fields: the captured CP0 values.
- WAIT: on tlb_resp_valid, go to COMMIT. The counter increments each cycle; when it reaches TIMEOUT-1 without a response, go to COMMIT with err set. On op_flush, go to DRAIN.
- DRAIN: discard the response. On tlb_resp_valid or timeout, go to IDLE with no op_done and no CP0 write.
- COMMIT (one cycle): op_done=1, op_err=err, then go to IDLE.
  - If !err and TLBP, w_cp0_tlbp_ena=1. On hit, w_cp0_Index={(32-INDEX_W)'b0, resp_idx}; on miss, {1'b1, 31'b0}.
  - If !err and TLBR, w_cp0_tlbr_ena=1. w_cp0_EntryHi={hi[31:13],5'b0,hi[7:0]}; w_cp0_EntryLo0/1={6'b0, lo[25:0]}.
  - TLBWI/TLBWR: no CP0 write; the response is an acknowledge only.
- A response arriving in IDLE/ISSUE/COMMIT is ignored.
- Random counter: counts down by 1 every cycle and wraps from 0 to TLB_ENTRIES-1. It is independent of the FSM.
- CP0 data outputs are registered and hold their last value when the strobes are low.

## Timing
- Reset values:
  - state IDLE, op_ready=1.
  - op_done, op_err, tlb_req, w_cp0_tlbp_ena, w_cp0_tlbr_ena: 0.
  - All data outputs 0; random=TLB_ENTRIES-1.
- Accept at edge T, ISSUE in T+1. If the TLB is ready in the same cycle and responds in the next, COMMIT is at T+3.
- Minimum accept to op_done is 3 cycles. op_ready returns the cycle after COMMIT.
- Timeout: with no response, COMMIT occurs TIMEOUT cycles after entering WAIT.
- A flush and a response in the same WAIT cycle: flush wins, giving no op_done and no CP0 write.
- Reset mid-op returns to IDLE immediately and drops all strobes.

## Test plan
- TLBP hit: cp0_entryhi=0x12345_0AB, TLB ready immediately, hit idx=5 one cycle later -> op_done at T+3, w_cp0_tlbp_ena pulse, w_cp0_Index=0x00000005.
- TLBP miss -> w_cp0_Index=0x80000000; TLBR with resp_entryhi=0xFFFFFFFF, lo0=0xFFFFFFFF -> EntryHi=0xFFFFE0FF, EntryLo0=0x03FFFFFF, tlbr pulse.
- TLBWR: accept when random=3 while tlb_req_ready is held low 4 cycles -> tlb_req_idx stays 3 throughout, no CP0 strobe, op_done after ack.
- No response -> op_done with op_err=1 exactly TIMEOUT (64) cycles after entering WAIT, no CP0 strobe.
- op_flush in WAIT, response 2 cycles later -> no op_done, no strobes, op_ready high the cycle after the response.
- Random wraps 0 -> 15 with TLB_ENTRIES=16; async reset asserted in WAIT -> all outputs at reset values, random=15.
